// File: rtl/legv8_pkg.sv
// Shared LegV8 definitions: condition codes, ALU status bit positions, default datapath width.
package legv8_pkg;

    localparam int DATA_W_DEFAULT = 64;

    localparam int ST_V = 3;
    localparam int ST_C = 2;
    localparam int ST_N = 1;
    localparam int ST_Z = 0;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_HS = 4'd2;
    localparam logic [3:0] COND_LO = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;

endpackage

// File: rtl/legv8_cond_eval.sv
// Combinational LegV8 B.cond evaluator; flags use the ALU status order {V,C,N,Z}.
module legv8_cond_eval
    import legv8_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic v, c, n, z;

    always_comb begin
        v = flags[ST_V];
        c = flags[ST_C];
        n = flags[ST_N];
        z = flags[ST_Z];
        taken = 1'b1;
        case (cond)
            COND_EQ: taken = z;
            COND_NE: taken = !z;
            COND_HS: taken = c;
            COND_LO: taken = !c;
            COND_MI: taken = n;
            COND_PL: taken = !n;
            COND_VS: taken = v;
            COND_VC: taken = !v;
            COND_HI: taken = c & !z;
            COND_LS: taken = !c | z;
            COND_GE: taken = (n == v);
            COND_LT: taken = (n != v);
            COND_GT: taken = !z & (n == v);
            COND_LE: taken = z | (n != v);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result buffer: NZCV flags register, B.cond resolution at push,
// and a small valid/ready FIFO toward writeback/branch logic.
module alu_result_stage
    import legv8_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = 2,
    parameter int REG_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_F,
    input  logic [3:0]        in_status,
    input  logic              in_set_flags,
    input  logic              in_wr_en,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_cond_check,
    input  logic [3:0]        in_cond,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_F,
    output logic              out_wr_en,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_taken,
    output logic [3:0]        flags
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] f_q     [DEPTH];
    logic [DATA_W-1:0] f_d     [DEPTH];
    logic              wr_en_q [DEPTH];
    logic              wr_en_d [DEPTH];
    logic [REG_W-1:0]  rd_q    [DEPTH];
    logic [REG_W-1:0]  rd_d    [DEPTH];
    logic              taken_q [DEPTH];
    logic              taken_d [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        flags_q, flags_d;

    logic push, pop, cond_taken;

    legv8_cond_eval u_cond_eval (
        .cond  (in_cond),
        .flags (flags_q),
        .taken (cond_taken)
    );

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        f_d      = f_q;
        wr_en_d  = wr_en_q;
        rd_d     = rd_q;
        taken_d  = taken_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        flags_d  = flags_q;

        // The ALU op executed even if the entry is flushed, so flags still update.
        if (push && in_set_flags) begin
            flags_d = in_status;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                f_d[wr_ptr_q]     = in_F;
                wr_en_d[wr_ptr_q] = in_wr_en;
                rd_d[wr_ptr_q]    = in_rd;
                taken_d[wr_ptr_q] = in_cond_check & cond_taken;
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            flags_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                f_q[i]     <= '0;
                wr_en_q[i] <= 1'b0;
                rd_q[i]    <= '0;
                taken_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                f_q[i]     <= f_d[i];
                wr_en_q[i] <= wr_en_d[i];
                rd_q[i]    <= rd_d[i];
                taken_q[i] <= taken_d[i];
            end
        end
    end

    assign out_F     = f_q[rd_ptr_q];
    assign out_wr_en = wr_en_q[rd_ptr_q];
    assign out_rd    = rd_q[rd_ptr_q];
    assign out_taken = taken_q[rd_ptr_q];
    assign flags     = flags_q;

endmodule
